// File: rtl/cache_packet_responder_if.sv
// rtl/cache_packet_responder_if.sv - request/return packet bundle between requesters and cache_packet_responder
interface cache_packet_responder_if #(
  parameter int NUM_WAY = 2,
  parameter int PKT_W   = 615
);

  // Requests from the cache side, one packet per way, way i at [i*PKT_W +: PKT_W]
  logic [PKT_W*NUM_WAY-1:0] request_packet_flatted_in;
  // One-cycle accept pulse per way
  logic [NUM_WAY-1:0]       request_packet_ack_flatted_out;
  // Read return packets, one per way
  logic [PKT_W*NUM_WAY-1:0] return_packet_flatted_out;
  // Return consumed, per way
  logic [NUM_WAY-1:0]       return_packet_ack_flatted_in;
  // Accepted transaction counters
  logic [31:0]              write_count_out;
  logic [31:0]              read_count_out;

  // Requester side (cache / packet generator / testbench)
  modport master (
    output request_packet_flatted_in,
    output return_packet_ack_flatted_in,
    input  request_packet_ack_flatted_out,
    input  return_packet_flatted_out,
    input  write_count_out,
    input  read_count_out
  );

  // Responder side (the behavioural memory)
  modport slave (
    input  request_packet_flatted_in,
    input  return_packet_ack_flatted_in,
    output request_packet_ack_flatted_out,
    output return_packet_flatted_out,
    output write_count_out,
    output read_count_out
  );

endinterface

// File: rtl/cache_packet_responder.sv
// rtl/cache_packet_responder.sv - behavioural next-level memory answering unified-cache request packets
module cache_packet_responder #(
  parameter int NUM_WAY                  = 2,
  parameter int NUM_ENTRY                = 32,
  parameter int LATENCY                  = 2,
  parameter int BLOCK_SIZE_IN_BITS       = 512,
  parameter int CPU_ADDR_LEN_IN_BITS     = 32,
  parameter int BLOCK_OFFSET_LEN_IN_BITS = 6,
  parameter int PORT_ID_WIDTH            = 2,
  parameter int TYPE_WIDTH               = 2,
  parameter int BYTE_MASK_LEN            = BLOCK_SIZE_IN_BITS / 8,
  parameter int PKT_W                    = BLOCK_SIZE_IN_BITS + CPU_ADDR_LEN_IN_BITS + BYTE_MASK_LEN
                                           + PORT_ID_WIDTH + TYPE_WIDTH + 3
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  cache_packet_responder_if.slave  bus
);

  // Packet layout, LSB first: data | addr | byte mask | port id | type | cacheable | is_write | valid
  localparam int DATA_POS  = 0;
  localparam int ADDR_POS  = DATA_POS + BLOCK_SIZE_IN_BITS;
  localparam int MASK_POS  = ADDR_POS + CPU_ADDR_LEN_IN_BITS;
  localparam int PORT_POS  = MASK_POS + BYTE_MASK_LEN;
  localparam int TYPE_POS  = PORT_POS + PORT_ID_WIDTH;
  localparam int CACHE_POS = TYPE_POS + TYPE_WIDTH;
  localparam int WRITE_POS = CACHE_POS + 1;
  localparam int VALID_POS = WRITE_POS + 1;

  localparam int IDX_W = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
  localparam int PTR_W = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef logic [PKT_W-1:0]              pkt_t;
  typedef logic [BLOCK_SIZE_IN_BITS-1:0] block_t;

  // Assemble a packet from its fields
  function automatic pkt_t packet_concat(
    input block_t                          data,
    input logic [CPU_ADDR_LEN_IN_BITS-1:0] addr,
    input logic [BYTE_MASK_LEN-1:0]        mask,
    input logic [PORT_ID_WIDTH-1:0]        port_id,
    input logic [TYPE_WIDTH-1:0]           pkt_type,
    input logic                            cacheable,
    input logic                            is_write,
    input logic                            valid
  );
    packet_concat = {valid, is_write, cacheable, pkt_type, port_id, mask, addr, data};
  endfunction

  // Storage
  block_t                          r_mem [NUM_ENTRY];

  // Arbiter state
  logic [NUM_WAY-1:0]              r_ack;
  logic [PTR_W-1:0]                r_rr_ptr;

  // Counters
  logic [31:0]                     r_write_count;
  logic [31:0]                     r_read_count;

  // Per-way return slots
  logic [CNT_W-1:0]                r_lat_cnt  [NUM_WAY];
  block_t                          r_lat_data [NUM_WAY];
  logic [CPU_ADDR_LEN_IN_BITS-1:0] r_lat_addr [NUM_WAY];
  logic [PORT_ID_WIDTH-1:0]        r_lat_port [NUM_WAY];
  logic [TYPE_WIDTH-1:0]           r_lat_type [NUM_WAY];
  logic                            r_lat_cache[NUM_WAY];
  pkt_t                            r_ret_pkt  [NUM_WAY];

  // Combinational request view
  pkt_t                            w_req_pkt  [NUM_WAY];
  logic [NUM_WAY-1:0]              w_ret_valid;
  logic [NUM_WAY-1:0]              w_eligible;
  logic                            w_grant_valid;
  logic [PTR_W-1:0]                w_grant_idx;
  logic [NUM_WAY-1:0]              w_grant_onehot;
  logic [PTR_W-1:0]                w_ptr_next;

  // Fields of the granted request
  pkt_t                            w_gnt_pkt;
  logic                            w_gnt_write;
  block_t                          w_gnt_data;
  logic [CPU_ADDR_LEN_IN_BITS-1:0] w_gnt_addr;
  logic [BYTE_MASK_LEN-1:0]        w_gnt_mask;
  logic [PORT_ID_WIDTH-1:0]        w_gnt_port;
  logic [TYPE_WIDTH-1:0]           w_gnt_type;
  logic                            w_gnt_cache;
  logic [IDX_W-1:0]                w_gnt_mem_idx;

  logic [PKT_W*NUM_WAY-1:0]        w_ret_flat;

  // Unpack requests and decide which ways may be granted this cycle
  always_comb begin
    for (int i = 0; i < NUM_WAY; i++) begin
      w_req_pkt[i]   = bus.request_packet_flatted_in[i*PKT_W +: PKT_W];
      w_ret_valid[i] = r_ret_pkt[i][VALID_POS];
      // A read needs its return slot fully idle; a write never produces a return
      w_eligible[i]  = w_req_pkt[i][VALID_POS] && !r_ack[i] &&
                       (w_req_pkt[i][WRITE_POS] || ((r_lat_cnt[i] == '0) && !w_ret_valid[i]));
    end
  end

  // Round-robin pick: first eligible way at or after the pointer
  always_comb begin
    logic [PTR_W:0] cand;
    w_grant_valid  = 1'b0;
    w_grant_idx    = '0;
    w_grant_onehot = '0;
    cand           = '0;
    for (int k = 0; k < NUM_WAY; k++) begin
      cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_WAY)) begin
        cand = cand - (PTR_W+1)'(NUM_WAY);
      end
      if (!w_grant_valid && w_eligible[cand[PTR_W-1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = cand[PTR_W-1:0];
      end
    end
    if (w_grant_valid) begin
      w_grant_onehot[w_grant_idx] = 1'b1;
    end
    w_ptr_next = (w_grant_idx == PTR_W'(NUM_WAY - 1)) ? '0 : w_grant_idx + 1'b1;
  end

  // Decode the winning request's fields
  always_comb begin
    w_gnt_pkt     = w_req_pkt[w_grant_idx];
    w_gnt_write   = w_gnt_pkt[WRITE_POS];
    w_gnt_data    = w_gnt_pkt[DATA_POS +: BLOCK_SIZE_IN_BITS];
    w_gnt_addr    = w_gnt_pkt[ADDR_POS +: CPU_ADDR_LEN_IN_BITS];
    w_gnt_mask    = w_gnt_pkt[MASK_POS +: BYTE_MASK_LEN];
    w_gnt_port    = w_gnt_pkt[PORT_POS +: PORT_ID_WIDTH];
    w_gnt_type    = w_gnt_pkt[TYPE_POS +: TYPE_WIDTH];
    w_gnt_cache   = w_gnt_pkt[CACHE_POS];
    // Upper address bits fold onto the same block: aliasing is intended
    w_gnt_mem_idx = w_gnt_addr[BLOCK_OFFSET_LEN_IN_BITS +: IDX_W];
  end

  // Register the grant as the ack pulse and advance the round-robin pointer
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_ack    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_ack <= w_grant_onehot;
      if (w_grant_valid) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  // Byte-masked write into the addressed block on a write grant
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        r_mem[e] <= '0;
      end
    end else if (w_grant_valid && w_gnt_write) begin
      for (int b = 0; b < BYTE_MASK_LEN; b++) begin
        if (w_gnt_mask[b]) begin
          r_mem[w_gnt_mem_idx][b*8 +: 8] <= w_gnt_data[b*8 +: 8];
        end
      end
    end
  end

  // Count accepted writes and reads
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_write_count <= '0;
      r_read_count  <= '0;
    end else if (w_grant_valid) begin
      if (w_gnt_write) begin
        r_write_count <= r_write_count + 32'd1;
      end else begin
        r_read_count  <= r_read_count + 32'd1;
      end
    end
  end

  // Return slots: latch read data at grant, count down the latency, hold until consumed
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < NUM_WAY; i++) begin
        r_lat_cnt[i]   <= '0;
        r_lat_data[i]  <= '0;
        r_lat_addr[i]  <= '0;
        r_lat_port[i]  <= '0;
        r_lat_type[i]  <= '0;
        r_lat_cache[i] <= 1'b0;
        r_ret_pkt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WAY; i++) begin
        if (w_grant_valid && !w_gnt_write && (w_grant_idx == PTR_W'(i))) begin
          // Memory read here sees every write granted on an earlier edge
          r_lat_data[i]  <= r_mem[w_gnt_mem_idx];
          r_lat_addr[i]  <= w_gnt_addr;
          r_lat_port[i]  <= w_gnt_port;
          r_lat_type[i]  <= w_gnt_type;
          r_lat_cache[i] <= w_gnt_cache;
          if (LATENCY == 1) begin
            r_ret_pkt[i] <= packet_concat(r_mem[w_gnt_mem_idx], w_gnt_addr, '0, w_gnt_port,
                                          w_gnt_type, w_gnt_cache, 1'b0, 1'b1);
          end else begin
            r_lat_cnt[i] <= CNT_W'(LATENCY - 1);
          end
        end else if (r_lat_cnt[i] != '0) begin
          r_lat_cnt[i] <= r_lat_cnt[i] - 1'b1;
          if (r_lat_cnt[i] == CNT_W'(1)) begin
            r_ret_pkt[i] <= packet_concat(r_lat_data[i], r_lat_addr[i], '0, r_lat_port[i],
                                          r_lat_type[i], r_lat_cache[i], 1'b0, 1'b1);
          end
        end else if (w_ret_valid[i] && bus.return_packet_ack_flatted_in[i]) begin
          r_ret_pkt[i] <= '0;
        end
      end
    end
  end

  // Flatten return packets onto the bus
  always_comb begin
    w_ret_flat = '0;
    for (int i = 0; i < NUM_WAY; i++) begin
      w_ret_flat[i*PKT_W +: PKT_W] = r_ret_pkt[i];
    end
  end

  assign bus.request_packet_ack_flatted_out = r_ack;
  assign bus.return_packet_flatted_out      = w_ret_flat;
  assign bus.write_count_out                = r_write_count;
  assign bus.read_count_out                 = r_read_count;

endmodule

// File: tb/tb_cache_packet_responder.sv
// tb/tb_cache_packet_responder.sv - self-checking bench for cache_packet_responder
module tb_cache_packet_responder;

  localparam int NUM_WAY   = 2;
  localparam int NUM_ENTRY = 32;
  localparam int LATENCY   = 2;
  localparam int BLK       = 512;
  localparam int AW        = 32;
  localparam int MW        = 64;
  localparam int PKT_W     = 615;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;
  int n_rd   = 0;

  logic [BLK-1:0] model_mem [NUM_ENTRY];

  cache_packet_responder_if #(.NUM_WAY(NUM_WAY), .PKT_W(PKT_W)) bus ();

  cache_packet_responder #(
    .NUM_WAY   (NUM_WAY),
    .NUM_ENTRY (NUM_ENTRY),
    .LATENCY   (LATENCY)
  ) dut (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  function automatic logic [PKT_W-1:0] mk_pkt(input logic v, input logic w, input logic c,
                                               input logic [1:0] ty, input logic [1:0] pid,
                                               input logic [MW-1:0] m, input logic [AW-1:0] a,
                                               input logic [BLK-1:0] d);
    return {v, w, c, ty, pid, m, a, d};
  endfunction

  function automatic int blk_of(input logic [AW-1:0] a);
    return int'((a / 64) % NUM_ENTRY);
  endfunction

  function automatic logic [BLK-1:0] rand_block();
    logic [BLK-1:0] r;
    for (int k = 0; k < BLK / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [BLK-1:0] d, input logic [MW-1:0] m);
    int e;
    e = blk_of(a);
    for (int b = 0; b < MW; b++) begin
      if (m[b]) model_mem[e][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic model_clear();
    for (int e = 0; e < NUM_ENTRY; e++) model_mem[e] = '0;
    n_wr = 0;
    n_rd = 0;
  endtask

  task automatic set_req(input int port, input logic [PKT_W-1:0] pkt);
    bus.request_packet_flatted_in[port*PKT_W +: PKT_W] = pkt;
  endtask

  // Issue one request, wait for its ack, update the model; exp is the return a read should produce
  task automatic do_req(input int port, input logic w, input logic [AW-1:0] a, input logic [BLK-1:0] d,
                        input logic [MW-1:0] m, input logic c, input logic [1:0] ty,
                        output logic [PKT_W-1:0] exp);
    logic ok;
    ok  = 1'b0;
    exp = '0;
    set_req(port, mk_pkt(1'b1, w, c, ty, 2'(port), m, a, d));
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.request_packet_ack_flatted_out[port]) ok = 1'b1;
    end
    set_req(port, '0);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL req_ack port%0d: ack not seen in 20 cycles, required ack", port);
    end else if (w) begin
      model_write(a, d, m);
      n_wr++;
    end else begin
      exp = mk_pkt(1'b1, 1'b0, c, ty, 2'(port), '0, a, model_mem[blk_of(a)]);
      n_rd++;
    end
  endtask

  // Wait for a return on port, compare it, consume it, confirm it clears
  task automatic expect_ret(input int port, input logic [PKT_W-1:0] exp, input string name);
    logic ok;
    logic [PKT_W-1:0] got;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (bus.return_packet_flatted_out[port*PKT_W + PKT_W - 1]) ok = 1'b1;
      else @(negedge clk);
    end
    got = bus.return_packet_flatted_out[port*PKT_W +: PKT_W];
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
    bus.return_packet_ack_flatted_in[port] = 1'b1;
    @(negedge clk);
    bus.return_packet_ack_flatted_in[port] = 1'b0;
    got = bus.return_packet_flatted_out[port*PKT_W +: PKT_W];
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s_clear: got %h required 0", name, got);
    end
  endtask

  task automatic check_counts(input string name);
    checks++;
    if (bus.write_count_out !== 32'(n_wr) || bus.read_count_out !== 32'(n_rd)) begin
      errors++;
      $display("FAIL %s: got wr=%0d rd=%0d required wr=%0d rd=%0d", name,
               bus.write_count_out, bus.read_count_out, n_wr, n_rd);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.request_packet_ack_flatted_out !== '0 || bus.return_packet_flatted_out !== '0 ||
        bus.write_count_out !== 32'd0 || bus.read_count_out !== 32'd0) begin
      errors++;
      $display("FAIL %s: got ack=%b wr=%0d rd=%0d ret_nonzero=%0d required all 0", name,
               bus.request_packet_ack_flatted_out, bus.write_count_out, bus.read_count_out,
               bus.return_packet_flatted_out != '0);
    end
  endtask

  task automatic test_reset();
    bus.request_packet_flatted_in    = '0;
    bus.return_packet_ack_flatted_in = '0;
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  // Both ways request reads on the same cycle; 'first' is where the pointer currently sits
  task automatic sim_reads(input int first, input string name);
    logic [AW-1:0]    a   [2];
    logic [PKT_W-1:0] exp [2];
    logic             c   [2];
    logic [1:0]       ty  [2];
    int               t_ack [2];
    int               t_rv  [2];
    int               second;
    second = 1 - first;
    for (int p = 0; p < 2; p++) begin
      a[p]     = $urandom;
      c[p]     = 1'($urandom_range(0, 1));
      ty[p]    = 2'($urandom_range(0, 3));
      t_ack[p] = -1;
      t_rv[p]  = -1;
      exp[p]   = '0;
      set_req(p, mk_pkt(1'b1, 1'b0, c[p], ty[p], 2'(p), '0, a[p], '0));
    end
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (t_ack[p] < 0 && bus.request_packet_ack_flatted_out[p]) begin
          t_ack[p] = t;
          set_req(p, '0);
          exp[p] = mk_pkt(1'b1, 1'b0, c[p], ty[p], 2'(p), '0, a[p], model_mem[blk_of(a[p])]);
          n_rd++;
        end
        if (t_rv[p] < 0 && bus.return_packet_flatted_out[p*PKT_W + PKT_W - 1]) t_rv[p] = t;
      end
    end
    set_req(0, '0);
    set_req(1, '0);
    checks++;
    if (t_ack[first] != 1 || t_ack[second] != 2) begin
      errors++;
      $display("FAIL %s_ack_order: got ack%0d@%0d ack%0d@%0d required @1 and @2", name,
               first, t_ack[first], second, t_ack[second]);
    end
    checks++;
    if (t_rv[first] != LATENCY || t_rv[second] != LATENCY + 1) begin
      errors++;
      $display("FAIL %s_ret_timing: got rv%0d@%0d rv%0d@%0d required @%0d and @%0d", name,
               first, t_rv[first], second, t_rv[second], LATENCY, LATENCY + 1);
    end
    expect_ret(first, exp[first], {name, "_ret_first"});
    expect_ret(second, exp[second], {name, "_ret_second"});
  endtask

  task automatic test_arbitration();
    logic [PKT_W-1:0] exp;
    sim_reads(0, "arb_after_reset");
    do_req(0, 1'b1, 32'h0000_0080, rand_block(), '1, 1'b1, 2'd0, exp);
    sim_reads(1, "arb_after_p0");
  endtask

  task automatic test_write_read();
    logic [PKT_W-1:0] exp;
    do_req(0, 1'b1, 32'h0000_1000, {16{32'h5}}, '1, 1'b1, 2'd1, exp);
    do_req(1, 1'b0, 32'h0000_1000, '0, '0, 1'b1, 2'd1, exp);
    expect_ret(1, mk_pkt(1'b1, 1'b0, 1'b1, 2'd1, 2'd1, '0, 32'h0000_1000, {16{32'h5}}), "write_read_ret");
    check_counts("write_read_counts");
  endtask

  task automatic test_byte_mask();
    logic [PKT_W-1:0] exp;
    logic [BLK-1:0]   want;
    do_req(0, 1'b1, 32'h0000_1040, {16{32'hAABBCCDD}}, '1, 1'b1, 2'd0, exp);
    do_req(1, 1'b1, 32'h0000_1040, '0, 64'h000F, 1'b1, 2'd0, exp);
    do_req(0, 1'b0, 32'h0000_1040, '0, '0, 1'b0, 2'd2, exp);
    want = {16{32'hAABBCCDD}};
    want[31:0] = 32'h0;
    checks++;
    if (exp[BLK-1:0] !== want) begin
      errors++;
      $display("FAIL byte_mask_model: got %h required %h", exp[BLK-1:0], want);
    end
    expect_ret(0, exp, "byte_mask_ret");
  endtask

  task automatic test_backpressure();
    logic [PKT_W-1:0] exp1;
    logic [PKT_W-1:0] exp2;
    logic [PKT_W-1:0] held;
    int bad;
    logic ok;
    do_req(1, 1'b0, 32'h0000_1000, '0, '0, 1'b1, 2'd3, exp1);
    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge clk);
      if (bus.return_packet_flatted_out[PKT_W + PKT_W - 1]) ok = 1'b1;
    end
    set_req(1, mk_pkt(1'b1, 1'b0, 1'b0, 2'd2, 2'd1, '0, 32'h0000_1040, '0));
    bad = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      held = bus.return_packet_flatted_out[PKT_W +: PKT_W];
      if (held !== exp1 || bus.request_packet_ack_flatted_out[1] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: got %0d bad cycles required 0", bad);
    end
    bus.return_packet_ack_flatted_in[1] = 1'b1;
    @(negedge clk);
    bus.return_packet_ack_flatted_in[1] = 1'b0;
    checks++;
    if (bus.return_packet_flatted_out[PKT_W +: PKT_W] !== '0 || bus.request_packet_ack_flatted_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: got ack1=%b ret_nonzero=%0d required ack1=0 ret=0",
               bus.request_packet_ack_flatted_out[1], bus.return_packet_flatted_out[PKT_W +: PKT_W] != '0);
    end
    @(negedge clk);
    checks++;
    if (bus.request_packet_ack_flatted_out[1] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_second_ack: got %b required 1", bus.request_packet_ack_flatted_out[1]);
    end
    set_req(1, '0);
    exp2 = mk_pkt(1'b1, 1'b0, 1'b0, 2'd2, 2'd1, '0, 32'h0000_1040, model_mem[blk_of(32'h0000_1040)]);
    n_rd++;
    expect_ret(1, exp2, "backpressure_second_ret");
  endtask

  task automatic test_aliasing();
    logic [PKT_W-1:0] exp;
    logic [BLK-1:0]   d;
    d = rand_block();
    do_req(0, 1'b1, 32'h0000_1000, d, '1, 1'b1, 2'd0, exp);
    do_req(1, 1'b0, 32'h0000_1000 + 32 * 64, '0, '0, 1'b1, 2'd0, exp);
    checks++;
    if (exp[BLK-1:0] !== d) begin
      errors++;
      $display("FAIL alias_model: got %h required %h", exp[BLK-1:0], d);
    end
    expect_ret(1, exp, "alias_ret");
  endtask

  task automatic test_random();
    logic [PKT_W-1:0] exp;
    int port;
    logic w;
    for (int n = 0; n < 40; n++) begin
      port = $urandom_range(0, 1);
      w    = 1'($urandom_range(0, 1));
      do_req(port, w, $urandom, rand_block(), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), exp);
      if (!w) expect_ret(port, exp, "random_ret");
    end
    check_counts("random_counts");
  endtask

  task automatic test_reset_inflight();
    logic [PKT_W-1:0] exp;
    int bad;
    do_req(0, 1'b1, 32'h0000_2000, rand_block(), '1, 1'b1, 2'd0, exp);
    do_req(0, 1'b0, 32'h0000_2000, '0, '0, 1'b1, 2'd0, exp);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_inflight_immediate");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bus.return_packet_flatted_out !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_no_stale_return: got %0d cycles with return required 0", bad);
    end
    do_req(1, 1'b0, 32'h0000_2000, '0, '0, 1'b1, 2'd0, exp);
    expect_ret(1, mk_pkt(1'b1, 1'b0, 1'b1, 2'd0, 2'd1, '0, 32'h0000_2000, '0), "reset_mem_cleared");
    check_counts("reset_counts");
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_write_read();
    test_byte_mask();
    test_backpressure();
    test_aliasing();
    test_random();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
